imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle MIPS core. It receives a byte stream (length header, big-endian instruction words, XOR checksum) and writes each assembled word into instruction memory. It holds the core in reset until a complete, checksum-valid image is written. It then releases the core to fetch from `BASE_ADDR`.

## Interface
Parameters:
- `IMEM_DEPTH`, 64: instruction memory capacity in 32-bit words; the maximum accepted word count.
- `BASE_ADDR`, 32'h0: byte address of the first word written.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; loader returns to `LEN_HI` immediately.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `byte_valid && byte_ready` at the edge.
- `reload`  in  1  single-cycle pulse; restarts loading from `DONE` or `ERROR`.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  32  byte address of the write.
- `imem_wdata`  out  32  instruction word.
- `core_reset`  out  1  active-high reset to the MIPS core.
- `done`  out  1  image loaded and verified.
- `error`  out  1  load failed (length overflow or checksum mismatch).

## Operation
- Stream format: `LEN[15:8]`, `LEN[7:0]`, then LEN words of 4 bytes each, MSB first, then 1 checksum byte.
  - The checksum byte must equal the XOR of every preceding byte, including both length bytes.
- States and transitions:
  - `LEN_HI` → `LEN_LO` on a transfer.
  - `LEN_LO` → `DATA` if 0 < LEN ≤ IMEM_DEPTH.
  - `LEN_LO` → `CHECK` if LEN = 0.
  - `LEN_LO` → `ERROR` if LEN > IMEM_DEPTH. The length check completes on the `LEN_LO` transfer edge.
  - `DATA` → `CHECK` after the 4th byte of word LEN-1.
  - `CHECK` → `DONE` if the checksum matches, otherwise → `ERROR`.
  - `DONE` / `ERROR` → `LEN_HI` on `reload`.
- Counters:
  - 2-bit byte index, wraps 3→0 on each completed word.
  - 16-bit word index, cleared on entry to `LEN_HI`.
  - 8-bit running XOR.
- Write address = `BASE_ADDR + 4*word_index`, 32-bit, wrap ignored (bounded by `IMEM_DEPTH`).
- `byte_ready` = 1 in `LEN_HI`, `LEN_LO`, `DATA` and `CHECK`; 0 in `DONE` and `ERROR`. Bytes offered in `DONE`/`ERROR` are not consumed.
- `core_reset` = 1 in every state except `DONE`. Re-entering `LEN_HI` via `reload` reasserts it.
- `reload` while not in `DONE`/`ERROR` is ignored. `reload` simultaneous with a byte in `DONE` restarts; the byte is not consumed.
- `byte_valid` low mid-word stalls all counters; no timeout.

## Timing
- Reset values: state `LEN_HI`, `byte_ready` = 1, `imem_we` = 0, `imem_addr` = `BASE_ADDR`, `imem_wdata` = 0, `core_reset` = 1, `done` = 0, `error` = 0.
- All outputs are registered.
- Word write: 4th byte accepted at edge k → `imem_we` = 1 with the final addr/data for the cycle after k. `imem_we` is 0 at edge k+1.
- Back-to-back bytes at full rate are supported. The write of word i overlaps the reception of word i+1 bytes without stall.
- Checksum byte accepted at edge c → `done` = 1 and `core_reset` = 0 (or `error` = 1) from the cycle after c. `done` and `error` are never both 1.
- LEN > IMEM_DEPTH: `error` = 1 the cycle after the `LEN_LO` transfer. No `imem_we` is ever issued for that image.
- `reset` asserted mid-load: all outputs take reset values asynchronously. A pending `imem_we` is dropped.
- `reload` at edge r → `LEN_HI`, `done`/`error` = 0, `core_reset` = 1 from the cycle after r.

## Structure
- Shared package `mips_pkg`:
  - `loader_state_t` enum (`LEN_HI`, `LEN_LO`, `DATA`, `CHECK`, `DONE`, `ERROR`).
  - Constant `WORD_BYTES` = 4.
- Single module, no sub-module. The byte assembler, counters and FSM are small enough to live in one file.
- In the top-level build, the MIPS top ties `core_reset` into the existing PC/register file reset. `imem_we`/`imem_addr`/`imem_wdata` drive a write port added to `instructionMemory`.

## Test plan
- LEN = 2, words 32'h20080005, 32'h2009000A, correct checksum → two `imem_we` pulses at addr 0 and 4 with those data; `done` = 1 and `core_reset` = 0 the cycle after the checksum byte.
- Same image with checksum bit 0 flipped → both writes occur; `error` = 1, `done` = 0, `core_reset` stays 1.
- LEN = 65 with IMEM_DEPTH = 64 → `error` = 1 the cycle after the 2nd byte; zero `imem_we` pulses; `byte_ready` = 0.
- LEN = 0, checksum 8'h00 → `done` = 1 with no writes.
- Random `byte_valid` gaps inside words plus `reset` pulled low mid-word 2 → outputs at reset values immediately; reloading the full image then completes correctly.
- From `DONE`, `reload` pulse plus new image with LEN = 1, word 32'hFFFFFFFF → `core_reset` reasserts, write at addr `BASE_ADDR`, `done` again.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS boot path (program loader FSM states).
package mips_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned BIDX_W     = 2;
  localparam int unsigned SHIFT_W    = (WORD_BYTES - 1) * BYTE_W;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  // Terminal states stop consuming bytes until a reload.
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s != DONE) && (s != ERROR);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a length/word/checksum byte stream into instruction
// memory writes and holds the core in reset until a verified image is present.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  loader_state_t        state_q, state_d;
  logic [BIDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [LEN_W-1:0]     word_idx_q, word_idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [BYTE_W-1:0]    xor_q, xor_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;

  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic [WORD_W-1:0]    addr_q, addr_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
  logic                 core_rst_q, core_rst_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 xfer;
  logic [LEN_W-1:0]     len_full;
  logic [LEN_W-1:0]     word_idx_inc;
  logic                 last_byte_of_word;

  assign xfer              = byte_valid && ready_q;
  assign len_full          = {len_q[LEN_W-1:BYTE_W], byte_data};
  assign word_idx_inc      = word_idx_q + LEN_W'(1);
  assign last_byte_of_word = (byte_idx_q == BIDX_W'(WORD_BYTES - 1));

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    xor_d      = xor_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    error_d    = error_q;

    unique case (state_q)
      LEN_HI: begin
        if (xfer) begin
          len_d[LEN_W-1:BYTE_W] = byte_data;
          xor_d                 = xor_q ^ byte_data;
          state_d               = LEN_LO;
        end
      end

      LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          xor_d = xor_q ^ byte_data;
          if (len_full == '0) begin
            state_d = CHECK;
          end else if (WORD_W'(len_full) > WORD_W'(IMEM_DEPTH)) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (xfer) begin
          xor_d      = xor_q ^ byte_data;
          byte_idx_d = byte_idx_q + BIDX_W'(1);
          if (last_byte_of_word) begin
            we_d       = 1'b1;
            addr_d     = BASE_ADDR + {word_idx_q[LEN_W-3:0], 2'b00} + {WORD_W'(word_idx_q[LEN_W-1:LEN_W-2]) << LEN_W};
            wdata_d    = {shift_q, byte_data};
            word_idx_d = word_idx_inc;
            if (word_idx_inc == len_q) begin
              state_d = CHECK;
            end
          end else begin
            shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_data};
          end
        end
      end

      CHECK: begin
        if (xfer) begin
          if (byte_data == xor_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end

      DONE, ERROR: begin
        if (reload) begin
          state_d    = LEN_HI;
          byte_idx_d = '0;
          word_idx_d = '0;
          len_d      = '0;
          xor_d      = '0;
          shift_d    = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          core_rst_d = 1'b1;
        end
      end

      default: begin
        state_d = LEN_HI;
      end
    endcase

    ready_d = accepts_bytes(state_d);
  end

  // State and output registers; reset drops any pending write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LEN_HI;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      len_q      <= '0;
      xor_q      <= '0;
      shift_q    <= '0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      shift_q    <= shift_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_rst_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares them whenever imem_we is seen.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors;
  int  miscompares;

  imem_loader #(.IMEM_DEPTH(64), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          miscompares++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
  endtask

  task automatic send_stream(input logic [7:0] b[$], input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      send_byte(b[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
    check({tag, "_imem_we"},    32'(imem_we),    32'd0);
    check({tag, "_imem_addr"},  imem_addr,       32'h0);
    check({tag, "_imem_wdata"}, imem_wdata,      32'h0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
  endtask

  logic [7:0] img_ok[$];
  logic [7:0] img_bad[$];
  logic [7:0] img_ovf[$];
  logic [7:0] img_zero[$];
  logic [7:0] img_three[$];
  logic [7:0] img_ones[$];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    reload      = 1'b0;

    img_ok    = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
    img_bad   = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0D};
    img_ovf   = '{8'h00, 8'h41};
    img_zero  = '{8'h00, 8'h00, 8'h00};
    img_three = '{8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A,
                  8'h01, 8'h09, 8'h50, 8'h20, 8'h75};
    img_ones  = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};

    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // Good two-word image; nothing released before the checksum byte.
    push_wr(32'h0, 32'h20080005);
    push_wr(32'h4, 32'h2009000A);
    send_stream(img_ok, 10, 0);
    check("ok_pre_done",       32'(done),       32'd0);
    check("ok_pre_core_reset", 32'(core_reset), 32'd1);
    send_stream('{img_ok[10]}, 1, 0);
    check("ok_done",       32'(done),       32'd1);
    check("ok_core_reset", 32'(core_reset), 32'd0);
    check("ok_error",      32'(error),      32'd0);
    check("ok_byte_ready", 32'(byte_ready), 32'd0);
    check("ok_writes_left", 32'(exp_q.size()), 32'd0);

    pulse_reload();
    check("rl1_done",       32'(done),       32'd0);
    check("rl1_core_reset", 32'(core_reset), 32'd1);
    check("rl1_byte_ready", 32'(byte_ready), 32'd1);

    // Same image, bad checksum.
    push_wr(32'h0, 32'h20080005);
    push_wr(32'h4, 32'h2009000A);
    send_stream(img_bad, 11, 0);
    check("bad_error",      32'(error),      32'd1);
    check("bad_done",       32'(done),       32'd0);
    check("bad_core_reset", 32'(core_reset), 32'd1);
    check("bad_writes_left", 32'(exp_q.size()), 32'd0);

    pulse_reload();
    // Length overflow: error right after the second header byte.
    send_stream(img_ovf, 2, 0);
    check("ovf_error",      32'(error),      32'd1);
    check("ovf_byte_ready", 32'(byte_ready), 32'd0);
    check("ovf_done",       32'(done),       32'd0);

    // Byte offered in ERROR and during the reload edge must not be consumed.
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check("err_hold_error", 32'(error), 32'd1);
    reload = 1'b1;
    @(negedge clk);
    reload     = 1'b0;
    byte_valid = 1'b0;
    check("rl2_error",      32'(error),      32'd0);
    check("rl2_byte_ready", 32'(byte_ready), 32'd1);

    // Zero-length image.
    send_stream(img_zero, 3, 0);
    check("zero_done",       32'(done),       32'd1);
    check("zero_core_reset", 32'(core_reset), 32'd0);
    check("zero_error",      32'(error),      32'd0);

    pulse_reload();
    // Gapped stream, reset pulled mid word 2.
    push_wr(32'h0, 32'h20080005);
    push_wr(32'h4, 32'h2009000A);
    send_stream(img_three, 12, 2);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push_wr(32'h0, 32'h20080005);
    push_wr(32'h4, 32'h2009000A);
    push_wr(32'h8, 32'h01095020);
    send_stream(img_three, 15, 2);
    check("three_done",        32'(done),        32'd1);
    check("three_core_reset",  32'(core_reset),  32'd0);
    check("three_writes_left", 32'(exp_q.size()), 32'd0);

    pulse_reload();
    check("rl3_core_reset", 32'(core_reset), 32'd1);
    check("rl3_done",       32'(done),       32'd0);
    push_wr(32'h0, 32'hFFFFFFFF);
    send_stream(img_ones, 7, 0);
    check("ones_done",        32'(done),        32'd1);
    check("ones_core_reset",  32'(core_reset),  32'd0);
    check("ones_writes_left", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
